// File: rtl/drsstc_pkg.sv
// -----------------------------------------------------------------------------
// drsstc_pkg
// Shared definitions for the DRSSTC controller: configuration array geometry,
// ASCII digit bounds, UART receiver and pulse generator state encodings, the
// configuration digit array type and a two-digit BCD to binary helper.
// -----------------------------------------------------------------------------
package drsstc_pkg;

    localparam int CONF_PAR_MAX = 5;
    localparam int CONF_PAR_4   = 4;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        G_IDLE,
        G_OFF,
        G_PRE,
        G_ON
    } gen_state_t;

    // Index 0 is the most recently received digit.
    typedef logic [CONF_PAR_MAX-1:0][CONF_PAR_4-1:0] conf_t;

    // Two decimal digits to a binary count (0..99 fits in 7 bits).
    function automatic logic [6:0] bcd2(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, idle-high line.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   i_rx     : raw UART line, asynchronous to clk
//   o_byte   : last received byte, meaningful while o_valid is high
//   o_valid  : one-clock strobe after a frame whose stop bit read high
// -----------------------------------------------------------------------------
module uart_rx
    import drsstc_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid
);

    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam int HALF = CLK_PER_BIT / 2;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    uart_state_t       r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bit;
    logic              r_valid;
    logic [7:0]        r_shift;
    logic              w_bit_mid;

    assign w_bit_mid = (r_cnt == CW'(CLK_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronizer resets to the idle level so release is not a start edge.
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= U_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= 1'b0;
            case (r_state)
                U_IDLE: begin
                    r_cnt <= '0;
                    if (r_prev && !r_sync2) begin
                        r_state <= U_START;
                    end
                end
                U_START: begin
                    // Half a bit in: a high line means the edge was a glitch.
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? U_IDLE : U_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (w_bit_mid) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= U_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (w_bit_mid) begin
                        r_cnt   <= '0;
                        r_valid <= r_sync2;
                        r_state <= U_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= U_IDLE;
            endcase
        end
    end

    // Data path carries no reset; it is qualified by r_valid.
    always_ff @(posedge clk) begin
        if (r_state == U_DATA && w_bit_mid) begin
            r_shift <= {r_sync2, r_shift[7:1]};
        end
    end

    assign o_byte  = r_shift;
    assign o_valid = r_valid;

endmodule

// File: rtl/drsstc_entry.sv
// -----------------------------------------------------------------------------
// drsstc_entry
// DRSSTC controller top: receives ASCII digits over UART into a five-digit
// configuration shift register and generates the interrupter pulse train.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   uart_data : UART line (8N1, LSB first, idle high)
//   sh_reg    : configuration digits, index 0 newest
//   out       : interrupter gate output
//   out_pred  : pre-drive output, rises T_pre units before out
// Timing: T_on = sh[1]sh[0], T_off = sh[3]sh[2], T_pre = min(sh[4], T_off),
// all in units of UNIT_CYC clocks.
// -----------------------------------------------------------------------------
module drsstc_entry
    import drsstc_pkg::*;
#(
    parameter int CLK_PER_BIT  = 16,
    parameter int CONF_PAR_MAX = 5,
    parameter int CONF_PAR_4   = 4,
    parameter int UNIT_CYC     = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     uart_data,
    output logic [CONF_PAR_MAX-1:0][CONF_PAR_4-1:0]  sh_reg,
    output logic                                     out,
    output logic                                     out_pred
);

    localparam int DW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

    logic [7:0]  w_byte;
    logic        w_valid;
    logic        w_is_digit;

    logic [6:0]  w_ton;
    logic [6:0]  w_toff;
    logic [6:0]  w_tpre;
    gen_state_t  w_first_st;
    logic        w_first_out;
    logic        w_first_pred;

    gen_state_t  r_state;
    logic [6:0]  r_ton;
    logic [6:0]  r_toff;
    logic [6:0]  r_tpre;
    logic [DW-1:0] r_div;
    logic [6:0]  r_cnt;
    logic        r_out;
    logic        r_pred;
    logic [6:0]  w_len;
    logic        w_tick;
    logic        w_end;

    uart_rx #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rx    (uart_data),
        .o_byte  (w_byte),
        .o_valid (w_valid)
    );

    assign w_is_digit = w_valid && (w_byte >= ASCII_0) && (w_byte <= ASCII_9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg <= '0;
        end else if (w_is_digit) begin
            sh_reg <= {sh_reg[CONF_PAR_MAX-2:0], w_byte[CONF_PAR_4-1:0]};
        end
    end

    // Live parameters from the digit register; only sampled into the shadow
    // copies at the start of a period.
    assign w_ton  = bcd2(sh_reg[1], sh_reg[0]);
    assign w_toff = bcd2(sh_reg[3], sh_reg[2]);
    assign w_tpre = (7'(sh_reg[4]) < w_toff) ? 7'(sh_reg[4]) : w_toff;

    // First non-empty phase of a new period.
    always_comb begin
        w_first_st = G_ON;
        if (w_toff != w_tpre) begin
            w_first_st = G_OFF;
        end else if (w_tpre != 7'd0) begin
            w_first_st = G_PRE;
        end
    end
    assign w_first_out  = (w_first_st == G_ON);
    assign w_first_pred = (w_first_st != G_OFF);

    always_comb begin
        case (r_state)
            G_OFF:   w_len = r_toff - r_tpre;
            G_PRE:   w_len = r_tpre;
            default: w_len = r_ton;
        endcase
    end

    assign w_tick = (r_div == DW'(UNIT_CYC - 1));
    assign w_end  = w_tick && (r_cnt == w_len - 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= G_IDLE;
            r_ton   <= '0;
            r_toff  <= '0;
            r_tpre  <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_pred  <= 1'b0;
        end else begin
            // Unit prescaler and elapsed-unit counter restart on every phase.
            if (r_state == G_IDLE || w_end) begin
                r_div <= '0;
                r_cnt <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                r_cnt <= r_cnt + 7'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end

            case (r_state)
                G_IDLE: begin
                    if (w_ton != 7'd0) begin
                        r_ton   <= w_ton;
                        r_toff  <= w_toff;
                        r_tpre  <= w_tpre;
                        r_state <= w_first_st;
                        r_out   <= w_first_out;
                        r_pred  <= w_first_pred;
                    end
                end
                G_OFF: begin
                    if (w_end) begin
                        r_state <= (r_tpre != 7'd0) ? G_PRE : G_ON;
                        r_pred  <= 1'b1;
                        r_out   <= (r_tpre == 7'd0);
                    end
                end
                G_PRE: begin
                    if (w_end) begin
                        r_state <= G_ON;
                        r_out   <= 1'b1;
                        r_pred  <= 1'b1;
                    end
                end
                G_ON: begin
                    if (w_end) begin
                        if (w_ton == 7'd0) begin
                            r_state <= G_IDLE;
                            r_out   <= 1'b0;
                            r_pred  <= 1'b0;
                        end else begin
                            r_ton   <= w_ton;
                            r_toff  <= w_toff;
                            r_tpre  <= w_tpre;
                            r_state <= w_first_st;
                            r_out   <= w_first_out;
                            r_pred  <= w_first_pred;
                        end
                    end
                end
                default: r_state <= G_IDLE;
            endcase
        end
    end

    assign out      = r_out;
    assign out_pred = r_pred;

endmodule

// File: tb/tb_drsstc_entry.sv
module tb_drsstc_entry;
    import drsstc_pkg::*;

    localparam int CPB = 16;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  uart_data = 1'b1;
    conf_t sh_reg;
    logic  out;
    logic  out_pred;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic mon_pl_en = 1'b0;
    int   pl_cnt = 0;
    logic mon_lv_en = 1'b0;
    logic mon_lv_val = 1'b0;
    int   lv_cnt = 0;

    typedef struct {
        logic [7:0] ch;
        conf_t      exp;
    } vec_t;
    vec_t vt[23];

    drsstc_entry #(
        .CLK_PER_BIT  (CPB),
        .CONF_PAR_MAX (5),
        .CONF_PAR_4   (4),
        .UNIT_CYC     (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_data (uart_data),
        .sh_reg    (sh_reg),
        .out       (out),
        .out_pred  (out_pred)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_pl_en && !out_pred) pl_cnt <= pl_cnt + 1;
        if (mon_lv_en && (out != mon_lv_val || out_pred != mon_lv_val)) lv_cnt <= lv_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_data = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_data = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_data = stop;
        repeat (CPB) @(negedge clk);
        uart_data = 1'b1;
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_frame(vt[i].ch, 1'b1);
            chk($sformatf("vec%0d_sh", i), 32'(sh_reg), 32'(vt[i].exp));
        end
    endtask

    // Waits for a transition of out (sel_pred=0) or out_pred (sel_pred=1) to level.
    task automatic wait_edge(input bit sel_pred, input logic level, input int budget,
                             input string nm, output int t);
        logic prev;
        logic v;
        bit   hit;
        int   n;
        prev = sel_pred ? out_pred : out;
        hit  = 1'b0;
        n    = 0;
        t    = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            v = sel_pred ? out_pred : out;
            if (v == level && prev != level) begin
                hit = 1'b1;
                t   = cyc;
            end
            prev = v;
            n++;
        end
        if (!hit) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no edge within %0d cycles", nm, budget);
        end
    endtask

    task automatic measure(input string tag, input int e_lead, input int e_on, input int e_off);
        int t0, t1, t2, t3, t4;
        wait_edge(1'b0, 1'b0, 400, {tag, "_sync"}, t0);
        wait_edge(1'b1, 1'b1, 400, {tag, "_predrise"}, t1);
        wait_edge(1'b0, 1'b1, 400, {tag, "_outrise"}, t2);
        wait_edge(1'b0, 1'b0, 400, {tag, "_outfall"}, t3);
        chk({tag, "_pred_falls_with_out"}, 32'(out_pred), 32'd0);
        wait_edge(1'b0, 1'b1, 400, {tag, "_outrise2"}, t4);
        chk({tag, "_lead"}, 32'(t2 - t1), 32'(e_lead));
        chk({tag, "_on"},   32'(t3 - t2), 32'(e_on));
        chk({tag, "_off"},  32'(t4 - t3), 32'(e_off));
    endtask

    initial begin
        int t0, t1, t2, n;
        bit hit;

        vt[0]  = '{8'h34, 20'h00004};
        vt[1]  = '{8'h32, 20'h00042};
        vt[2]  = '{8'h34, 20'h00424};
        vt[3]  = '{8'h32, 20'h04242};
        vt[4]  = '{8'h34, 20'h42424};
        vt[5]  = '{8'h37, 20'h24247};
        vt[6]  = '{8'h32, 20'h42472};
        vt[7]  = '{8'h34, 20'h24724};
        vt[8]  = '{8'h32, 20'h47242};
        vt[9]  = '{8'h34, 20'h72424};
        vt[10] = '{8'h34, 20'h24244};
        vt[11] = '{8'h35, 20'h42445};
        vt[12] = '{8'h41, 20'h42445};
        vt[13] = '{8'h30, 20'h44530};
        vt[14] = '{8'h30, 20'h45300};
        vt[15] = '{8'h30, 20'h53000};
        vt[16] = '{8'h30, 20'h30000};
        vt[17] = '{8'h30, 20'h00000};
        vt[18] = '{8'h39, 20'h00009};
        vt[19] = '{8'h30, 20'h00090};
        vt[20] = '{8'h35, 20'h00905};
        vt[21] = '{8'h31, 20'h09051};
        vt[22] = '{8'h30, 20'h90510};

        repeat (4) @(negedge clk);
        chk("rst_sh", 32'(sh_reg), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_pred", 32'(out_pred), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // "42424": T_on=24, T_off=24, T_pre=4
        apply_range(0, 4);
        measure("cfgA", 4, 24, 24);

        // "7242445": T_on=45, T_off=24, T_pre=4
        apply_range(5, 11);
        measure("cfgB", 4, 45, 24);

        // Non-digit, framing error, glitch
        apply_range(12, 12);
        send_frame(8'h31, 1'b0);
        repeat (4) @(negedge clk);
        chk("badstop_sh", 32'(sh_reg), 32'h42445);
        uart_data = 1'b0;
        repeat (2) @(negedge clk);
        uart_data = 1'b1;
        repeat (12) @(negedge clk);
        send_frame(8'h33, 1'b1);
        chk("glitch_then_3_sh", 32'(sh_reg), 32'h24453);

        // All zeros: generator returns to idle
        apply_range(13, 17);
        hit = 1'b0;
        n = 0;
        while (!hit && n < 400) begin
            @(negedge clk);
            if (!out && !out_pred) hit = 1'b1;
            n++;
        end
        lv_cnt = 0;
        mon_lv_val = 1'b0;
        mon_lv_en = 1'b1;
        repeat (300) @(negedge clk);
        mon_lv_en = 1'b0;
        chk("idle_outputs_low", 32'(lv_cnt), 32'd0);

        // Clamp: sh[4]=9, T_off=5 -> T_pre=5, OFF skipped
        apply_range(18, 22);
        wait_edge(1'b0, 1'b0, 400, "clamp_sync", t0);
        chk("clamp_pred_at_fall", 32'(out_pred), 32'd1);
        pl_cnt = 0;
        mon_pl_en = 1'b1;
        wait_edge(1'b0, 1'b1, 400, "clamp_rise", t1);
        mon_pl_en = 1'b0;
        chk("clamp_pred_low_cycles", 32'(pl_cnt), 32'd0);
        wait_edge(1'b0, 1'b0, 400, "clamp_fall", t2);
        chk("clamp_off", 32'(t1 - t0), 32'd5);
        chk("clamp_on", 32'(t2 - t1), 32'd10);

        // Asynchronous reset mid-byte and mid-ON
        fork
            send_frame(8'h37, 1'b1);
            begin
                repeat (64) @(negedge clk);
                hit = 1'b0;
                n = 0;
                while (!hit && n < 100) begin
                    @(negedge clk);
                    if (out) hit = 1'b1;
                    n++;
                end
                chk("pre_reset_on", 32'(out), 32'd1);
                #2 rst_n = 1'b0;
                #1;
                chk("arst_sh", 32'(sh_reg), 32'd0);
                chk("arst_out", 32'(out), 32'd0);
                chk("arst_pred", 32'(out_pred), 32'd0);
            end
        join
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // "8" alone: T_on=8, T_off=0 -> outputs continuously high
        send_frame(8'h38, 1'b1);
        chk("after_rst_sh", 32'(sh_reg), 32'h00008);
        repeat (4) @(negedge clk);
        chk("cont_out", 32'(out), 32'd1);
        chk("cont_pred", 32'(out_pred), 32'd1);
        lv_cnt = 0;
        mon_lv_val = 1'b1;
        mon_lv_en = 1'b1;
        repeat (100) @(negedge clk);
        mon_lv_en = 1'b0;
        chk("cont_high_cycles", 32'(lv_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/drsstc_entry.md
# drsstc_entry

Top-level control block of the DRSSTC controller. It receives ASCII decimal digits over a 1-wire UART input and shifts them into a five-entry configuration register. It drives the interrupter output `out` and a leading pre-drive output `out_pred` from that configuration.

## Interface
- `CLK_PER_BIT`, default 16: system clocks per UART bit; ≥ 4.
- `CONF_PAR_MAX`, default 5: number of configuration digit slots.
- `CONF_PAR_4`, default 4: width of one slot, which holds one BCD digit.
- `UNIT_CYC`, default 1: clocks per timing unit for the pulse generator.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart_data` in 1: UART line, 8N1, LSB first, idles high, asynchronous to `clk`.
- `sh_reg` out [CONF_PAR_MAX][CONF_PAR_4]: configuration digit register; index 0 is the newest digit.
- `out` out 1: interrupter gate output.
- `out_pred` out 1: pre-drive output; it leads `out`.

## Operation
- Reset values: `sh_reg` all 0, `out`=0, `out_pred`=0, UART receiver idle, generator in IDLE.
- UART receiver:
  - `uart_data` passes through a 2-flop synchronizer.
  - A start is a 1→0 edge seen while idle.
  - The start bit is re-checked low at CLK_PER_BIT/2; if it reads high, the frame is aborted and the receiver returns to idle.
  - The 8 data bits are sampled at mid-bit, every CLK_PER_BIT clocks, LSB first.
  - The stop bit is sampled at mid-bit. If it reads 0, the byte is discarded.
- Digit filter:
  - Only bytes 0x30–0x39 are accepted. Each accepted byte becomes one digit, d = byte − 0x30.
  - On acceptance: `sh_reg[i] <= sh_reg[i-1]` for i = 4..1, and `sh_reg[0] <= d`.
  - All other bytes are ignored and leave `sh_reg` unchanged.
- Derived parameters (decimal):
  - T_on = 10·sh[1] + sh[0]
  - T_off = 10·sh[3] + sh[2]
  - T_pre = min(sh[4], T_off)
  - All are in units of UNIT_CYC clocks, are at most 7 bits wide, and involve no overflow.
- Generator FSM:
  - IDLE: both outputs low. Move to OFF when shadow T_on ≠ 0.
  - OFF: lasts T_off − T_pre units; both outputs low. The phase is skipped when its length is 0.
  - PRE: lasts T_pre units; `out_pred`=1, `out`=0. The phase is skipped when T_pre = 0.
  - ON: lasts T_on units; both outputs 1. Afterwards go to OFF, or to IDLE if the new shadow T_on = 0.
- Shadow config: T_on, T_off and T_pre are latched from `sh_reg` only when entering OFF or when leaving IDLE. Mid-period UART updates therefore never truncate or glitch a pulse.
- `out` and `out_pred` are registered. `out` is never 1 while `out_pred` is 0.
- When T_off = 0 and T_on ≠ 0, both outputs stay continuously high.

## Timing
- A digit lands in `sh_reg` 1 clock after the stop-bit mid-sample, which is about 9.5·CLK_PER_BIT + 3 clocks after the start edge.
- Configuration becomes effective at the next OFF entry. From IDLE, this is 1 clock after `sh_reg` yields T_on ≠ 0.
- Period = T_off + T_on units. `out_pred` rises exactly T_pre units before `out`. Both outputs fall on the same clock.
- Asserting `rst_n` mid-frame or mid-pulse immediately forces all outputs to their reset values. A partial frame is dropped.
- Back-to-back frames are supported, with one stop bit between frames.

## Structure
- Shared package `drsstc_pkg` holds:
  - CONF_PAR_MAX and CONF_PAR_4
  - the ASCII_0 and ASCII_9 constants
  - the UART state enum (IDLE, START, DATA, STOP)
  - the generator state enum (IDLE, OFF, PRE, ON)
  - a `conf_t` typedef for the digit array
- Sub-module `uart_rx` contains the synchronizer, bit timing and byte/valid strobe. The top level contains the digit filter, shift register, shadow latch and pulse FSM.

## Test plan
- Stream "42424" (frames 0x34 0x32 0x34 0x32 0x34) → `sh_reg[0..4]` = 4,2,4,2,4. Pulses: T_on=24, T_off=24, T_pre=4, so `out_pred` leads `out` by 4 units.
- Stream "7242445" → `sh_reg[0..4]` = 5,4,4,2,4. Pulses: `out` high for 45 units, low for 24 units; `out_pred` rises 4 units before `out`.
- Send 'A' (0x41), then a frame with stop bit 0, then a 2-clock glitch low → `sh_reg` unchanged, no digit shifted in.
- Load "00000" while pulsing → the current ON phase completes, then both outputs stay low (IDLE).
- Set sh[4]=9 with T_off=5 → T_pre clamps to 5, OFF phase skipped, and `out_pred` is high for the whole off time.
- Pulse `rst_n` low mid-byte and mid-ON → outputs and `sh_reg` clear asynchronously. The next complete frame is received correctly.
